bcd_conv_arbiter: RTL

//  Shares one sequential binary-to-BCD converter (shift-add-3, one bit per cycle) between two requesters.

---
 rtl/bcd_conv_arbiter_if.sv | 27 ++
 rtl/bcd_conv_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared BCD converter.
// The master side drives requests and data; the slave side (the converter) answers.
interface bcd_conv_arbiter_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  req0_i;
   logic [WIDTH-1:0]      data0_i;
   logic                  gnt0_o;
   logic                  req1_i;
   logic [WIDTH-1:0]      data1_i;
   logic                  gnt1_o;
   logic                  busy_o;
   logic                  valid_o;
   logic                  owner_o;
   logic [4*DIGITS-1:0]   bcd_o;

   modport master (
      output req0_i, data0_i, req1_i, data1_i,
      input  gnt0_o, gnt1_o, busy_o, valid_o, owner_o, bcd_o
   );

   modport slave (
      input  req0_i, data0_i, req1_i, data1_i,
      output gnt0_o, gnt1_o, busy_o, valid_o, owner_o, bcd_o
   );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// One shift-add-3 binary-to-BCD converter shared round-robin by two requesters.
// Each job takes WIDTH cycles in CONV, then a single DONE cycle that flags the result.
module bcd_conv_arbiter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input logic               clk_i,
   input logic               rst_i,
   bcd_conv_arbiter_if.slave bus
);
   localparam int SW = 4*DIGITS + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   if (64'(10)**DIGITS <= (64'(1) << WIDTH) - 64'(1)) begin : gDigitCheck
      $error("bcd_conv_arbiter: DIGITS too small for WIDTH");
   end

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t              state_q;
   logic                rrPtr_q;
   logic                jobOwner_q;
   logic                owner_q;
   logic                valid_q;
   logic                busy_q;
   logic [CW-1:0]       cnt_q;
   logic [SW-1:0]       shift_q;
   logic [SW-1:0]       adj_d;
   logic [SW-1:0]       shift_d;
   logic [4*DIGITS-1:0] bcd_q;
   logic                canGrant;
   logic                grant0;
   logic                grant1;

   // Grants are only offered when the datapath is free; on a tie the pointer favours the other side.
   assign canGrant = (state_q == IDLE || state_q == DONE) && !rst_i;
   assign grant0   = canGrant && bus.req0_i && (!bus.req1_i || rrPtr_q);
   assign grant1   = canGrant && bus.req1_i && (!bus.req0_i || !rrPtr_q);

   always_comb begin
      adj_d = shift_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (shift_q[WIDTH + 4*i +: 4] >= 4'd5) begin
            adj_d[WIDTH + 4*i +: 4] = shift_q[WIDTH + 4*i +: 4] + 4'd3;
         end
      end
      shift_d = adj_d << 1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rrPtr_q    <= 1'b1;
         jobOwner_q <= 1'b0;
         owner_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
         shift_q    <= '0;
         bcd_q      <= '0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (grant0 || grant1) begin
                  shift_q    <= {{(4*DIGITS){1'b0}}, (grant1 ? bus.data1_i : bus.data0_i)};
                  jobOwner_q <= grant1;
                  rrPtr_q    <= grant1;
                  cnt_q      <= CW'(WIDTH);
                  busy_q     <= 1'b1;
                  state_q    <= CONV;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            CONV: begin
               shift_q <= shift_d;
               cnt_q   <= cnt_q - CW'(1);
               // The last iteration's shifted value goes straight to the output register.
               if (cnt_q == CW'(1)) begin
                  bcd_q   <= shift_d[SW-1:WIDTH];
                  owner_q <= jobOwner_q;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt0_o  = grant0;
   assign bus.gnt1_o  = grant1;
   assign bus.busy_o  = busy_q;
   assign bus.valid_o = valid_q;
   assign bus.owner_o = owner_q;
   assign bus.bcd_o   = bcd_q;
endmodule
